// File: rtl/lfsr_pkg.sv
// Shared command op codes and controller state encoding for the LFSR sequencer.
package lfsr_pkg;

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_RUN     = 2'b01;
  localparam logic [1:0] OP_MEASURE = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    MEASURE = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: shifts right with the tap parity entering the MSB.
module lfsr_core #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'h1D
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  assign q_next = {^(q_q & TAPS), q_q[WIDTH-1:1]};

  // load outranks step so the lock-up recovery overrides a pending step
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_value;
    end else if (step) begin
      q_d = q_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q <= '1;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for one LFSR: seed load, bounded/free-run bit streaming, period measurement.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'h1D,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_data,
  input  logic             abort,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_out,
  output logic [WIDTH-1:0] state_q,
  output logic             busy,
  output logic             done,
  output logic             lockup,
  output logic [CNT_W-1:0] period
);

  localparam logic [WIDTH-1:0] ONES    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_state_e      fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             lockup_q, lockup_d;
  logic             done_q, done_d;

  logic             core_step;
  logic             core_load;
  logic [WIDTH-1:0] core_load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] meas_next;

  assign seed = cmd_data[WIDTH-1:0];

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_core (
    .clk        (clk),
    .reset_n    (reset_n),
    .step       (core_step),
    .load       (core_load),
    .load_value (core_load_val),
    .q          (q),
    .q_next     (q_next)
  );

  always_comb begin
    fsm_d         = fsm_q;
    cnt_d         = cnt_q;
    start_d       = start_q;
    period_d      = period_q;
    lockup_d      = lockup_q;
    done_d        = 1'b0;
    core_step     = 1'b0;
    core_load     = 1'b0;
    core_load_val = ONES;
    meas_next     = q_next;

    unique case (fsm_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              core_load     = 1'b1;
              core_load_val = (seed == '0) ? ONES : seed;
              lockup_d      = 1'b0;
            end
            OP_RUN: begin
              cnt_d = cmd_data;
              fsm_d = RUN;
            end
            OP_MEASURE: begin
              start_d = q;
              cnt_d   = '0;
              fsm_d   = MEASURE;
            end
            default: ;
          endcase
        end
      end

      RUN: begin
        // all-zero register is replaced with all ones instead of stepping
        if (q == '0) begin
          core_load = 1'b1;
          lockup_d  = 1'b1;
        end else begin
          core_step = bit_ready;
        end
        if (bit_ready && (cnt_q != '0)) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (abort) begin
          fsm_d = IDLE;
        end else if (bit_ready && (cnt_q == CNT_ONE)) begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end
      end

      MEASURE: begin
        if (abort) begin
          fsm_d = IDLE;
        end else begin
          if (q == '0) begin
            core_load = 1'b1;
            lockup_d  = 1'b1;
            meas_next = ONES;
          end else begin
            core_step = 1'b1;
          end
          cnt_d = cnt_q + CNT_ONE;
          if (meas_next == start_q) begin
            period_d = cnt_q + CNT_ONE;
            done_d   = 1'b1;
            fsm_d    = IDLE;
          end else if ((cnt_q + CNT_ONE) == CNT_MAX) begin
            period_d = CNT_MAX;
            done_d   = 1'b1;
            fsm_d    = IDLE;
          end
        end
      end

      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q    <= IDLE;
      cnt_q    <= '0;
      start_q  <= '1;
      period_q <= '0;
      lockup_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      start_q  <= start_d;
      period_q <= period_d;
      lockup_q <= lockup_d;
      done_q   <= done_d;
    end
  end

  assign cmd_ready = (fsm_q == IDLE);
  assign busy      = (fsm_q != IDLE);
  assign bit_valid = (fsm_q == RUN);
  assign bit_out   = q[0];
  assign state_q   = q;
  assign done      = done_q;
  assign lockup    = lockup_q;
  assign period    = period_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: three instances (default, 3-bit, singular taps) share one command stream.
module tb_lfsr_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [15:0] cmd_data = '0;
  logic        abort = 1'b0;
  logic        bit_ready = 1'b0;

  logic        cmd_ready8, bit_valid8, bit_out8, busy8, done8, lockup8;
  logic [7:0]  q8;
  logic [15:0] period8;
  logic        cmd_ready3, bit_valid3, bit_out3, busy3, done3, lockup3;
  logic [2:0]  q3;
  logic [15:0] period3;
  logic        cmd_readyl, bit_validl, bit_outl, busyl, donel, lockupl;
  logic [7:0]  ql;
  logic [15:0] periodl;

  int n_pass = 0;
  int n_total = 0;
  logic [0:0] exp_q[$];

  lfsr_seq_ctrl u8 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready8),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .bit_valid(bit_valid8),
    .bit_ready(bit_ready), .bit_out(bit_out8), .state_q(q8), .busy(busy8),
    .done(done8), .lockup(lockup8), .period(period8)
  );

  lfsr_seq_ctrl #(.WIDTH(3), .TAPS(3'b011), .CNT_W(16)) u3 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready3),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .bit_valid(bit_valid3),
    .bit_ready(bit_ready), .bit_out(bit_out3), .state_q(q3), .busy(busy3),
    .done(done3), .lockup(lockup3), .period(period3)
  );

  lfsr_seq_ctrl #(.WIDTH(8), .TAPS(8'h80), .CNT_W(16)) ul (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_readyl),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .abort(abort), .bit_valid(bit_validl),
    .bit_ready(bit_ready), .bit_out(bit_outl), .state_q(ql), .busy(busyl),
    .done(donel), .lockup(lockupl), .period(periodl)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: shift right, new MSB = parity of tapped bits
  function automatic logic [7:0] m_step(input logic [7:0] x);
    int fb;
    fb = $countones(x & 8'h1D) % 2;
    return 8'((int'(x) / 2) + fb * 128);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] data);
    int w = 0;
    while (!(cmd_ready8 && cmd_ready3 && cmd_readyl) && w < 100) begin
      tick();
      w++;
    end
    chk("cmd_ready_wait", {31'd0, cmd_ready8 && cmd_ready3 && cmd_readyl}, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [7:0]  exp_q;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0] mq;
    logic [7:0] mq_final;
    logic [6:0] bits3;
    int hs_cnt;
    int cyc;
    int k;
    int n;
    int p;
    logic [7:0] x;

    tbl[0] = '{2'b00, 16'h0000, 8'hFF};
    tbl[1] = '{2'b00, 16'h0001, 8'h01};
    tbl[2] = '{2'b00, 16'h00A5, 8'hA5};
    tbl[3] = '{2'b11, 16'h0055, 8'hA5};
    tbl[4] = '{2'b00, 16'h0100, 8'hFF};
    tbl[5] = '{2'b00, 16'h003C, 8'h3C};

    // reset state
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_q", q8, 8'hFF);
    chk("rst_busy", busy8, 0);
    chk("rst_cmd_ready", cmd_ready8, 1);
    chk("rst_period", period8, 0);
    chk("rst_lockup", lockup8, 0);
    chk("rst_done", done8, 0);

    // table-driven load / reserved op vectors
    for (int i = 0; i < 6; i++) begin
      send_cmd(tbl[i].op, tbl[i].data);
      chk($sformatf("tbl_q[%0d]", i), q8, tbl[i].exp_q);
      chk($sformatf("tbl_busy[%0d]", i), busy8, 0);
      chk($sformatf("tbl_done[%0d]", i), done8, 0);
    end

    // 3-bit LFSR, taps 011, full 7-bit run
    bits3 = 7'b0100111;
    send_cmd(2'b00, 16'h0007);
    bit_ready = 1'b1;
    send_cmd(2'b01, 16'd7);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("w3_bit[%0d]", i), bit_out3, bits3[i]);
      chk($sformatf("w3_valid[%0d]", i), bit_valid3, 1);
      tick();
    end
    bit_ready = 1'b0;
    chk("w3_done", done3, 1);
    chk("w3_q", q3, 3'b111);
    chk("w3_busy", busy3, 0);
    tick();
    chk("w3_done_pulse", done3, 0);

    // period measurement, default taps
    send_cmd(2'b00, 16'h0001);
    send_cmd(2'b10, 16'h0000);
    k = 0;
    while (!done8 && k < 400) begin
      tick();
      k++;
    end
    chk("meas_cycles", k, 255);
    chk("meas_period", period8, 255);
    chk("meas_q", q8, 8'h01);
    chk("meas_busy", busy8, 0);
    chk("meas3_period", period3, 7);
    pulse_abort();
    chk("meas_done_pulse", done8, 0);
    send_cmd(2'b00, 16'h0000);
    chk("load0_q", q8, 8'hFF);

    // bounded run with toggling backpressure
    send_cmd(2'b00, 16'h00A5);
    mq = 8'hA5;
    send_cmd(2'b01, 16'd4);
    hs_cnt = 0;
    cyc = 0;
    while (hs_cnt < 4 && cyc < 20) begin
      bit_ready = (cyc % 2 == 0);
      chk($sformatf("tog_q[%0d]", cyc), q8, mq);
      chk($sformatf("tog_done[%0d]", cyc), done8, 0);
      if (bit_ready) begin
        mq = m_step(mq);
        hs_cnt++;
      end
      tick();
      cyc++;
    end
    bit_ready = 1'b0;
    chk("tog_final_done", done8, 1);
    chk("tog_final_q", q8, mq);
    chk("tog_final_busy", busy8, 0);

    // free run, 20 handshakes, then abort
    send_cmd(2'b00, 16'h005A);
    mq = 8'h5A;
    bit_ready = 1'b1;
    send_cmd(2'b01, 16'd0);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("free_bit[%0d]", i), bit_out8, mq[0]);
      mq = m_step(mq);
      tick();
    end
    bit_ready = 1'b0;
    pulse_abort();
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_q", q8, mq);
    tick();
    chk("abort_done_late", done8, 0);

    // abort coinciding with the final handshake: bit consumed, no done
    send_cmd(2'b00, 16'h00C3);
    mq = 8'hC3;
    send_cmd(2'b01, 16'd1);
    bit_ready = 1'b1;
    pulse_abort();
    bit_ready = 1'b0;
    chk("abort_hs_q", q8, m_step(mq));
    chk("abort_hs_busy", busy8, 0);
    chk("abort_hs_done", done8, 0);
    tick();
    chk("abort_hs_done_late", done8, 0);

    // reset in the middle of a run
    bit_ready = 1'b1;
    send_cmd(2'b01, 16'd0);
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bit_ready = 1'b0;
    chk("midrst_q", q8, 8'hFF);
    chk("midrst_busy", busy8, 0);
    chk("midrst_period", period8, 0);

    // lock-up recovery with singular taps
    send_cmd(2'b00, 16'h0001);
    bit_ready = 1'b1;
    send_cmd(2'b01, 16'd0);
    tick();
    chk("lk_zero_q", ql, 8'h00);
    chk("lk_not_yet", lockupl, 0);
    tick();
    chk("lk_reload_q", ql, 8'hFF);
    chk("lk_set", lockupl, 1);
    repeat (3) tick();
    chk("lk_sticky", lockupl, 1);
    chk("lk_still_busy", busyl, 1);
    bit_ready = 1'b0;
    pulse_abort();
    chk("lk_after_abort", lockupl, 1);
    chk("lk_default_clear", lockup8, 0);
    send_cmd(2'b00, 16'h0055);
    chk("lk_cleared", lockupl, 0);
    chk("lk_load_q", ql, 8'h55);

    // randomized runs against the model
    for (int it = 0; it < 16; it++) begin
      x = 8'($urandom_range(1, 255));
      n = $urandom_range(1, 12);
      send_cmd(2'b00, {8'h00, x});
      mq = x;
      exp_q.delete();
      for (int j = 0; j < n; j++) begin
        exp_q.push_back(mq[0]);
        mq = m_step(mq);
      end
      mq_final = mq;
      send_cmd(2'b01, 16'(n));
      cyc = 0;
      while (cyc < 200) begin
        bit_ready = 1'($urandom_range(0, 1));
        if (bit_ready && bit_valid8) begin
          if (exp_q.size() > 0) chk($sformatf("rnd_bit[%0d]", it), bit_out8, exp_q.pop_front());
          else chk($sformatf("rnd_extra[%0d]", it), bit_valid8, 0);
        end
        tick();
        cyc++;
        if (done8) break;
      end
      bit_ready = 1'b0;
      chk($sformatf("rnd_done[%0d]", it), done8, 1);
      chk($sformatf("rnd_left[%0d]", it), exp_q.size(), 0);
      chk($sformatf("rnd_q[%0d]", it), q8, mq_final);
      if (it % 8 == 7) begin
        p = 0;
        x = mq_final;
        do begin
          x = m_step(x);
          p++;
        end while (x != mq_final && p < 1000);
        send_cmd(2'b10, 16'h0000);
        k = 0;
        while (!done8 && k < 400) begin
          tick();
          k++;
        end
        chk($sformatf("rnd_period[%0d]", it), period8, p);
        chk($sformatf("rnd_meas_q[%0d]", it), q8, mq_final);
        pulse_abort();
      end
    end

    tick();
    chk("end_lockup3", lockup3, 0);
    chk("end_idle_l", {31'd0, busyl | bit_validl}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
